mux_4_1: RTL and testbench

MUX_4_1 -- requirements
Module: mux_4_1

---
 rtl/mux_4_1.sv | 49 ++++
 tb/tb_mux_4_1.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_4_1.sv
// Registered 4-to-1 multiplexer: on each rising clock edge, y captures the input chosen by {s1,s0}.
// sel_q records which select produced the current y.
module mux_4_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       sel_q
);

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_muxOut;
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;

    assign w_sel = {s1, s0};

    always_comb begin
        w_muxOut = '0;
        unique case (w_sel)
            2'b00:   w_muxOut = i0;
            2'b01:   w_muxOut = i1;
            2'b10:   w_muxOut = i2;
            default: w_muxOut = i3;
        endcase
    end

    // y and sel_q load on the same edge so they always describe each other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_sel <= 2'b00;
        end else begin
            r_y   <= w_muxOut;
            r_sel <= w_sel;
        end
    end

    assign y     = r_y;
    assign sel_q = r_sel;

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: 1-bit and 8-bit instances against a behavioural model,
// plus literal expectations for the directed scenarios.
module tb_mux_4_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s0 = 1'b0;
    logic       s1 = 1'b0;
    logic       d1 [4];
    logic [7:0] d8 [4];
    logic       y1;
    logic [7:0] y8;
    logic [1:0] selQ1;
    logic [1:0] selQ8;

    int passCount = 0;
    int checkCount = 0;
    bit checkEn = 1'b0;

    logic       modelY1;
    logic [7:0] modelY8;
    logic [1:0] modelSel;

    always #5 clk = ~clk;

    mux_4_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i0(d1[0]), .i1(d1[1]), .i2(d1[2]), .i3(d1[3]),
        .s0(s0), .s1(s1), .y(y1), .sel_q(selQ1)
    );

    mux_4_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .i0(d8[0]), .i1(d8[1]), .i2(d8[2]), .i3(d8[3]),
        .s0(s0), .s1(s1), .y(y8), .sel_q(selQ8)
    );

    // Model: output equals the data word indexed by the select seen at the last edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelY1  = 1'b0;
            modelY8  = 8'h00;
            modelSel = 2'd0;
        end else begin
            modelSel = 2'(int'(s1) * 2 + int'(s0));
            modelY1  = d1[modelSel];
            modelY8  = d8[modelSel];
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input int sel);
        s1 = sel[1];
        s0 = sel[0];
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_y1", {7'd0, y1}, {7'd0, modelY1});
            checkOutput("model_y8", y8, modelY8);
            checkOutput("model_selq1", {6'd0, selQ1}, {6'd0, modelSel});
            checkOutput("model_selq8", {6'd0, selQ8}, {6'd0, modelSel});
        end
    end

    initial begin
        logic [7:0] pat8 [4];
        logic       pat1 [4];
        logic       prevI2;
        pat8 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        pat1 = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            d1[k] = pat1[k];
            d8[k] = pat8[k];
        end
        applyStimulus(3);

        // Reset asserted before any clock edge, data and select nonzero
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset_y1", {7'd0, y1}, 8'h00);
        checkOutput("reset_y8", y8, 8'h00);
        checkOutput("reset_selq", {6'd0, selQ8}, 8'h00);
        checkEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_hold_y1", {7'd0, y1}, 8'h00);
        checkOutput("reset_hold_selq", {6'd0, selQ1}, 8'h00);

        // First capture after release happens at the next rising edge
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("first_capture_y8", y8, 8'h00);
        checkOutput("first_capture_selq", {6'd0, selQ8}, 8'h03);

        // Select sweep with literal expectations
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1 applyStimulus(k);
            @(negedge clk);
            checkOutput($sformatf("sweep_y1_%0d", k), {7'd0, y1}, {7'd0, pat1[k]});
            checkOutput($sformatf("sweep_y8_%0d", k), y8, pat8[k]);
            checkOutput($sformatf("sweep_selq_%0d", k), {6'd0, selQ8}, 8'(k));
        end

        // Mid-cycle select change 00 -> 01
        @(negedge clk); #1 applyStimulus(0);
        @(posedge clk); #2 applyStimulus(1);
        #1 checkOutput("midcycle_before_y1", {7'd0, y1}, 8'h00);
        @(negedge clk);
        checkOutput("midcycle_hold_y1", {7'd0, y1}, 8'h00);
        @(posedge clk); #1;
        checkOutput("midcycle_after_y1", {7'd0, y1}, 8'h01);
        checkOutput("midcycle_after_y8", y8, 8'h3C);

        // Asynchronous reset between edges while y1=1, release with sel=01, i1=1
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_y1", {7'd0, y1}, 8'h00);
        checkOutput("async_reset_selq", {6'd0, selQ1}, 8'h00);
        @(negedge clk); #1 rst_n = 1'b1;
        #1 checkOutput("release_wait_y1", {7'd0, y1}, 8'h00);
        @(posedge clk); #1;
        checkOutput("release_capture_y1", {7'd0, y1}, 8'h01);

        // Hold sel=10, toggle i2 while scrambling the others
        @(negedge clk); #1 applyStimulus(2);
        prevI2 = d1[2];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_i2_y1_%0d", c), {7'd0, y1}, {7'd0, prevI2});
            #1;
            d1[2] = ~d1[2];
            prevI2 = d1[2];
            d1[0] = 1'($urandom);
            d1[1] = 1'($urandom);
            d1[3] = 1'($urandom);
            d8[0] = 8'($urandom);
            d8[1] = 8'($urandom);
            d8[3] = 8'($urandom);
        end

        // Randomised traffic with mid-cycle changes and occasional reset pulses
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                d1[k] = 1'($urandom);
                d8[k] = 8'($urandom);
            end
            applyStimulus(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #2;
                applyStimulus(int'($urandom_range(0, 3)));
                d8[$urandom_range(0, 3)] = 8'($urandom);
            end
            if ($urandom_range(0, 29) == 0) begin
                @(posedge clk); #2 rst_n = 1'b0;
                #1 checkOutput("rand_reset_y8", y8, 8'h00);
                @(negedge clk); #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
